// File: rtl/bldc_deadtime.sv
// Three-phase gate dead-time inserter with shoot-through fault latch.
// Each phase runs its own OFF/DEAD/ON_H/ON_L FSM; the two gates of a phase can
// only switch sides after a dead period of dead_time_i+1 cycles with both off.
module bldc_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic [DT_W-1:0] dead_time_i,
    input  logic [5:0]      hbridge_i,
    input  logic            clear_fault_i,
    output logic [5:0]      gate_o,
    output logic [2:0]      dead_active_o,
    output logic            fault_o
);

    typedef enum logic [1:0] {StOff, StDead, StOnH, StOnL} state_e;

    state_e          state_q [3];
    state_e          state_d [3];
    logic [DT_W-1:0] cnt_q   [3];
    logic [DT_W-1:0] cnt_d   [3];
    logic            fault_q, fault_d;
    logic [5:0]      gate_q, gate_d;
    logic [2:0]      dead_q, dead_d;
    logic [2:0]      req_h, req_l;
    logic            illegal;

    // Request decode: only one-sided requests count, and none while disabled or faulted.
    always_comb begin
        req_h   = '0;
        req_l   = '0;
        illegal = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_h[k] = hbridge_i[2*k+1] & ~hbridge_i[2*k] & enable_i & ~fault_q;
            req_l[k] = ~hbridge_i[2*k+1] & hbridge_i[2*k] & enable_i & ~fault_q;
            illegal  = illegal | (hbridge_i[2*k+1] & hbridge_i[2*k]);
        end
    end

    // State register; reset forces OFF immediately with no dead period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= StOff;
                cnt_q[k]   <= '0;
            end
            fault_q <= 1'b0;
            gate_q  <= '0;
            dead_q  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            fault_q <= fault_d;
            gate_q  <= gate_d;
            dead_q  <= dead_d;
        end
    end

    // Next-state logic per phase; dead_time_i is sampled only when entering DEAD.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                StOff: begin
                    if (req_h[k]) begin
                        state_d[k] = StOnH;
                    end else if (req_l[k]) begin
                        state_d[k] = StOnL;
                    end
                end
                StOnH: begin
                    if (!req_h[k]) begin
                        state_d[k] = StDead;
                        cnt_d[k]   = dead_time_i;
                    end
                end
                StOnL: begin
                    if (!req_l[k]) begin
                        state_d[k] = StDead;
                        cnt_d[k]   = dead_time_i;
                    end
                end
                StDead: begin
                    if (cnt_q[k] != '0) begin
                        cnt_d[k] = cnt_q[k] - DT_W'(1);
                    end else if (req_h[k]) begin
                        state_d[k] = StOnH;
                    end else if (req_l[k]) begin
                        state_d[k] = StOnL;
                    end else begin
                        state_d[k] = StOff;
                    end
                end
                default: begin
                    state_d[k] = StOff;
                    cnt_d[k]   = '0;
                end
            endcase
        end
        // Set wins over clear when both happen in the same cycle.
        fault_d = illegal | (fault_q & ~clear_fault_i);
    end

    // Output decode from the next state, so the registered outputs track the state register.
    always_comb begin
        gate_d = '0;
        dead_d = '0;
        for (int k = 0; k < 3; k++) begin
            gate_d[2*k+1] = (state_d[k] == StOnH);
            gate_d[2*k]   = (state_d[k] == StOnL);
            dead_d[k]     = (state_d[k] == StDead);
        end
    end

    assign gate_o        = gate_q;
    assign dead_active_o = dead_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_bldc_deadtime.sv
// Directed scenarios plus a random run, checked every cycle against a
// behavioural model of the dead-time rules.
module tb_bldc_deadtime;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] dt = 8'd0;
    logic [5:0] hb = 6'd0;
    logic       clr = 1'b0;
    logic [5:0] gate;
    logic [2:0] dead;
    logic       fault;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Model: which side a phase is on (0 none, 1 high, 2 low) and the remaining
    // dead count (-1 when not in a dead period).
    int   m_side [3];
    int   m_left [3];
    bit   m_fault;
    logic [5:0] exp_gate;
    logic [2:0] exp_dead;

    bldc_deadtime #(.DT_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .dead_time_i  (dt),
        .hbridge_i    (hb),
        .clear_fault_i(clr),
        .gate_o       (gate),
        .dead_active_o(dead),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Never both gates of a phase on.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 3; k++) begin
                chk("no_shoot_through", {31'd0, gate[2*k+1] & gate[2*k]}, 32'd0);
            end
        end
    end

    task automatic model_step();
        int  req;
        bit  any_both;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_side[k] = 0;
                m_left[k] = -1;
            end
            m_fault = 1'b0;
        end else begin
            any_both = 1'b0;
            for (int k = 0; k < 3; k++) begin
                req = 0;
                if (en && !m_fault) begin
                    if (hb[2*k+1] && !hb[2*k]) req = 1;
                    if (!hb[2*k+1] && hb[2*k]) req = 2;
                end
                if (hb[2*k+1] && hb[2*k]) any_both = 1'b1;
                if (m_left[k] > 0) begin
                    m_left[k]--;
                end else if (m_left[k] == 0) begin
                    m_left[k] = -1;
                    m_side[k] = req;
                end else if (m_side[k] == 0) begin
                    m_side[k] = req;
                end else if (req != m_side[k]) begin
                    m_side[k] = 0;
                    m_left[k] = int'(dt);
                end
            end
            m_fault = any_both || (m_fault && !clr);
        end
        for (int k = 0; k < 3; k++) begin
            exp_gate[2*k+1] = (m_left[k] < 0) && (m_side[k] == 1);
            exp_gate[2*k]   = (m_left[k] < 0) && (m_side[k] == 2);
            exp_dead[k]     = (m_left[k] >= 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checking = 1'b1;
        chk("gate", {26'd0, gate}, {26'd0, exp_gate});
        chk("dead", {29'd0, dead}, {29'd0, exp_dead});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
    endtask

    // Phase A gap: count cycles with both A gates off (and dead cycles) until gate bit rises.
    task automatic gap(input int bit_idx, input int expected, input string tag,
                       input int change_at, input logic [7:0] new_dt);
        int n = 0;
        int nd = 0;
        int guard = 0;
        do begin
            tick();
            if (gate[1:0] === 2'b00) n++;
            if (dead[0] === 1'b1) nd++;
            guard++;
            if (guard == change_at) dt = new_dt;
        end while (gate[bit_idx] !== 1'b1 && guard < 64);
        chk(tag, n, expected);
        chk({tag, "_dead"}, nd, expected);
    endtask

    initial begin
        int n;
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("reset_gate", {26'd0, gate}, 32'd0);
        chk("reset_dead", {29'd0, dead}, 32'd0);
        chk("reset_fault", {31'd0, fault}, 32'd0);

        // Latency from OFF and D=8 high-to-low switch
        rst = 1'b0; en = 1'b1; dt = 8'd8; hb = 6'b000010;
        tick();
        chk("latency_off_h", {31'd0, gate[1]}, 32'd1);
        tick();
        hb = 6'b000001;
        gap(0, 9, "gap_d8", -1, 8'd0);

        // D=0 in both directions
        dt = 8'd0; hb = 6'b000010;
        gap(1, 1, "gap_d0_lh", -1, 8'd0);
        hb = 6'b000001;
        gap(0, 1, "gap_d0_hl", -1, 8'd0);

        // dead_time_i changed mid-DEAD does not affect the running count
        dt = 8'd5; hb = 6'b000010;
        gap(1, 6, "gap_dt_change", 2, 8'd20);

        // Shoot-through request while A is ON_H
        hb = 6'b000011;
        tick();
        chk("fault_set", {31'd0, fault}, 32'd1);
        hb = 6'b000010;
        for (int i = 0; i < 30; i++) tick();
        chk("fault_gates_off", {26'd0, gate}, 32'd0);
        chk("fault_a_off", {31'd0, dead[0]}, 32'd0);
        clr = 1'b1; hb = 6'b000011;
        tick();
        chk("clear_vs_set", {31'd0, fault}, 32'd1);
        hb = 6'b000000;
        tick();
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        clr = 1'b0; hb = 6'b000010;
        tick();
        chk("reenter_on", {31'd0, gate[1]}, 32'd1);

        // Reset mid-DEAD on A and mid-ON_L on B
        dt = 8'd8; hb = 6'b000101;
        tick();
        tick();
        tick();
        chk("pre_reset_dead", {31'd0, dead[0]}, 32'd1);
        chk("pre_reset_b_low", {31'd0, gate[2]}, 32'd1);
        rst = 1'b1;
        tick();
        chk("reset_mid_gate", {26'd0, gate}, 32'd0);
        chk("reset_mid_dead", {29'd0, dead}, 32'd0);
        rst = 1'b0; hb = 6'b000001;
        tick();
        chk("post_reset_l", {31'd0, gate[0]}, 32'd1);

        // enable_i dropped with B high and C low
        dt = 8'd3; hb = 6'b011000;
        for (int i = 0; i < 8; i++) tick();
        chk("bc_on", {26'd0, gate}, 32'h18);
        en = 1'b0;
        tick();
        chk("bc_dead_together", {30'd0, dead[2:1]}, 32'd3);
        n = 1;
        for (int i = 0; i < 32 && dead[2:1] === 2'b11; i++) begin
            tick();
            if (dead[2:1] === 2'b11) n++;
        end
        chk("bc_dead_len", n, 4);
        chk("bc_off", {26'd0, gate}, 32'd0);

        // Random run
        en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 11) != 0);
            clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) dt = 8'($urandom_range(0, 6));
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 40))
                        0:               hb[2*k+:2] = 2'b11;
                        1, 2, 3, 4, 5:   hb[2*k+:2] = 2'b00;
                        default:         hb[2*k+:2] = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                    endcase
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bldc_deadtime.md
BLDC_DEADTIME -- requirements
Module: bldc_deadtime

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter DT_W, default 8, meaning width of the dead-time count.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port enable_i, input, 1 bit: 0 forces every phase toward off.
REQ-006 The block SHALL have port dead_time_i, input, DT_W bits: dead-time count D.
REQ-007 The block SHALL have port hbridge_i, input, 6 bits: gate requests from bldc_controller hbridge_o. For phase k (A=0, B=1, C=2), bit 2k+1 is high side and bit 2k is low side.
REQ-008 The block SHALL have port clear_fault_i, input, 1 bit: clears the sticky fault.
REQ-009 The block SHALL have port gate_o, output, 6 bits: gate drive, with the same bit mapping as hbridge_i, registered.
REQ-010 The block SHALL have port dead_active_o, output, 3 bits: phase k is in DEAD, registered.
REQ-011 The block SHALL have port fault_o, output, 1 bit: sticky shoot-through request flag, registered.

Function
REQ-012 The block SHALL contain three identical independent per-phase FSMs: OFF, DEAD, ON_H, ON_L.
REQ-013 The effective request per phase SHALL be computed as follows:
- H-only = (H=1, L=0).
- L-only = (H=0, L=1).
- Any other input is treated as none.
- All requests are treated as none while enable_i=0 or fault_o=1.
REQ-014 In OFF, the FSM SHALL go to ON_H on H-only and to ON_L on L-only; otherwise it stays in OFF.
REQ-015 In ON_H, the FSM SHALL stay while the request is H-only; otherwise it goes to DEAD and loads its counter with dead_time_i.
REQ-016 ON_L SHALL behave symmetrically to ON_H.
REQ-017 In DEAD with counter != 0, the FSM SHALL decrement the counter and ignore requests.
REQ-018 In DEAD with counter == 0, the FSM SHALL go to ON_H on H-only, to ON_L on L-only, and otherwise to OFF.
REQ-019 dead_time_i SHALL be sampled only at the load; changes during DEAD have no effect on the running count.
REQ-020 Gate outputs SHALL follow the state of the current cycle:
- ON_H: high=1, low=0.
- ON_L: high=0, low=1.
- OFF and DEAD: both 0.
- dead_active_o[k] = 1 exactly in DEAD.
REQ-021 A high-to-low or low-to-high switch SHALL produce D+1 consecutive cycles with both gates 0; D=0 gives a 1-cycle gap.
REQ-022 Latency from OFF SHALL be as follows: a request seen at edge n drives the gate from edge n+1 (1 cycle).
REQ-023 Going from ON to none and back to the same side SHALL still pass through the full DEAD period.
REQ-024 fault_o SHALL be set at the edge following any cycle in which any phase has hbridge_i H=1 and L=1, regardless of enable_i.
REQ-025 fault_o SHALL be cleared by clear_fault_i=1.
REQ-026 If a set and clear_fault_i occur in the same cycle, set SHALL win.
REQ-027 While fault_o=1, all ON phases SHALL move to DEAD and then OFF, and no phase may re-enter ON.
REQ-028 gate_o[2k+1] and gate_o[2k] SHALL never both be 1 in any cycle, including under reset, fault, and enable changes.
REQ-029 Counters SHALL be DT_W bits, SHALL never wrap, and SHALL hold 0 outside DEAD.

Reset
REQ-030 On rst_i=1 at an edge, the block SHALL set all FSMs to OFF, counters to 0, gate_o=6'b0, dead_active_o=3'b0, and fault_o=0.
REQ-031 Reset SHALL take priority over all other inputs, including mid-DEAD and mid-ON; the next state is OFF with no dead period.
REQ-032 While rst_i=1, all outputs SHALL remain 0.

Verification
REQ-033 Scenario: D=8, phase A request high then switched to low -> gate_o[1] falls one edge after the change, 9 cycles with gate_o[1:0]=00, then gate_o[0]=1; dead_active_o[0]=1 for those 9 cycles.
REQ-034 Scenario: D=0, same A high-to-low switch -> exactly 1 cycle of 00 between gate_o[1]=1 and gate_o[0]=1.
REQ-035 Scenario: hbridge_i=6'b000011 for 1 cycle while phase A is ON_H -> fault_o=1 at next edge, A goes through DEAD to OFF, and gates stay 0 until clear_fault_i is pulsed; clear and illegal request in the same cycle keep fault_o=1.
REQ-036 Scenario: D=5 with dead_time_i changed to 20 during DEAD -> the gap remains 6 cycles.
REQ-037 Scenario: rst_i asserted in DEAD cycle 3 of 8 and in ON_L -> all outputs 0 at the next edge, and after release a new L-only request drives gate_o[0]=1 one cycle later.
REQ-038 Scenario: enable_i dropped while phases B and C are ON -> both enter DEAD simultaneously and go to OFF after D+1 cycles; an assertion checks REQ-028 throughout all scenarios.
